lstm_init_rx: RTL and testbench

Receiving end of the LSTM parameter-initialisation stream (iInit_valid / iInit_type / iInit_data).
- Accepts one byte per clock and classifies each byte by parameter type.
- Generates a byte-addressed write into the matching parameter buffer.
- Checks every segment's length against its expected size and publishes per-type "loaded" flags plus sticky error flags.
- Sits between the external init source and the LSTM weight/bias/context storage.

---
 rtl/lstm_init_pkg.sv | 44 ++++
 rtl/lstm_init_seg_cnt.sv | 47 ++++
 rtl/lstm_init_rx.sv | 161 ++++++++++++++++
 tb/tb_lstm_init_rx.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_init_pkg.sv
// lstm_init_pkg: shared definitions for the LSTM parameter-initialisation receiver.
//   - init_type_e : type codes carried on iInit_type
//   - rx_state_e  : receiver FSM states
//   - DEF_*_SIZE  : default segment sizes in bytes
//   - size_of()   : default segment size for a type code (0 for non-parameter codes)
package lstm_init_pkg;

  typedef enum logic [2:0] {
    SYSCALL_W   = 3'd0,
    SYSCALL_B   = 3'd1,
    SYSCALL_CTX = 3'd2,
    BRANCH_W    = 3'd3,
    BRANCH_B    = 3'd4,
    BRANCH_CTX  = 3'd5,
    TYPE_RSVD   = 3'd6,
    TYPE_IDLE   = 3'd7
  } init_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLOSE
  } rx_state_e;

  localparam int DEF_SYS_W_SIZE   = 32768;
  localparam int DEF_SYS_B_SIZE   = 256;
  localparam int DEF_SYS_CTX_SIZE = 128;
  localparam int DEF_BR_W_SIZE    = 32768;
  localparam int DEF_BR_B_SIZE    = 256;
  localparam int DEF_BR_CTX_SIZE  = 128;

  function automatic int size_of(input logic [2:0] t);
    case (t)
      SYSCALL_W:   size_of = DEF_SYS_W_SIZE;
      SYSCALL_B:   size_of = DEF_SYS_B_SIZE;
      SYSCALL_CTX: size_of = DEF_SYS_CTX_SIZE;
      BRANCH_W:    size_of = DEF_BR_W_SIZE;
      BRANCH_B:    size_of = DEF_BR_B_SIZE;
      BRANCH_CTX:  size_of = DEF_BR_CTX_SIZE;
      default:     size_of = 0;
    endcase
  endfunction

endpackage

// File: rtl/lstm_init_seg_cnt.sv
// lstm_init_seg_cnt: byte counter for the segment currently being received.
//   clk, rst : clock, synchronous active-high reset
//   start    : first byte of a new segment (count becomes 1, overflow cleared)
//   hit      : another byte of the open segment
//   size     : expected size of the open segment
//   addr     : write index for the next byte (count modulo 2**ADDR_W)
//   room     : count < size
//   full     : count == size
//   over     : a byte arrived after the segment was already full
module lstm_init_seg_cnt #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hit,
  input  logic [ADDR_W:0]   size,
  output logic [ADDR_W-1:0] addr,
  output logic              room,
  output logic              full,
  output logic              over
);

  localparam int CNT_W = ADDR_W + 1;

  // One extra bit so that a full segment's count equals its size exactly.
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      over  <= 1'b0;
    end else if (start) begin
      count <= CNT_W'(1);
      over  <= 1'b0;
    end else if (hit) begin
      // Saturate at size: surplus bytes only raise the overflow mark.
      if (room) count <= count + 1'b1;
      else      over  <= 1'b1;
    end
  end

  assign addr = count[ADDR_W-1:0];
  assign room = (count < size);
  assign full = (count == size);

endmodule

// File: rtl/lstm_init_rx.sv
// lstm_init_rx: receiving end of the LSTM parameter-initialisation byte stream.
//   clk, rst                 : clock, synchronous active-high reset
//   iInit_valid/type/data    : one parameter byte per clock, tagged with its type
//   iClear                   : clears loaded and error flags
//   oWr_en/sel/addr/data     : registered byte write into the selected parameter buffer
//   oLoaded[5:0]             : per-type segment received with exactly the right length
//   oSys_ready / oBr_ready   : all three syscall / branch segments loaded
//   oErr_short/over/type     : sticky length and type errors
module lstm_init_rx
  import lstm_init_pkg::*;
#(
  parameter int SYS_W_SIZE   = size_of(SYSCALL_W),
  parameter int SYS_B_SIZE   = size_of(SYSCALL_B),
  parameter int SYS_CTX_SIZE = size_of(SYSCALL_CTX),
  parameter int BR_W_SIZE    = size_of(BRANCH_W),
  parameter int BR_B_SIZE    = size_of(BRANCH_B),
  parameter int BR_CTX_SIZE  = size_of(BRANCH_CTX),
  parameter int ADDR_W       = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iInit_valid,
  input  logic [2:0]        iInit_type,
  input  logic [7:0]        iInit_data,
  input  logic              iClear,
  output logic              oWr_en,
  output logic [2:0]        oWr_sel,
  output logic [ADDR_W-1:0] oWr_addr,
  output logic [7:0]        oWr_data,
  output logic [5:0]        oLoaded,
  output logic              oSys_ready,
  output logic              oBr_ready,
  output logic              oErr_short,
  output logic              oErr_over,
  output logic              oErr_type
);

  localparam int CNT_W = ADDR_W + 1;

  rx_state_e        state;
  logic [2:0]       cur_type;
  // Set when CLOSE was entered because a new type arrived: that byte already
  // opened the next segment, so CLOSE continues it instead of acting as IDLE.
  logic             seg_live;
  // Verdict on the segment being closed, captured as it ends and applied in CLOSE.
  logic [2:0]       close_type;
  logic             close_ok;
  logic             close_short;

  logic [CNT_W-1:0]  seg_size;
  logic [ADDR_W-1:0] cnt_addr;
  logic              cnt_room, cnt_full, cnt_over;
  logic              accepted, seg_open, cnt_hit, cnt_start;
  logic [5:0]        loaded_nxt;

  always_comb begin
    case (cur_type)
      SYSCALL_W:   seg_size = CNT_W'(SYS_W_SIZE);
      SYSCALL_B:   seg_size = CNT_W'(SYS_B_SIZE);
      SYSCALL_CTX: seg_size = CNT_W'(SYS_CTX_SIZE);
      BRANCH_W:    seg_size = CNT_W'(BR_W_SIZE);
      BRANCH_B:    seg_size = CNT_W'(BR_B_SIZE);
      BRANCH_CTX:  seg_size = CNT_W'(BR_CTX_SIZE);
      default:     seg_size = '0;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    loaded_nxt = iClear ? 6'b0 : oLoaded;
    accepted   = iInit_valid && (iInit_type <= BRANCH_CTX);
    seg_open   = (state == ST_LOAD) || ((state == ST_CLOSE) && seg_live);
    cnt_hit    = seg_open && accepted && (iInit_type == cur_type);
    // Any accepted byte that does not continue the open segment starts a new one.
    cnt_start  = accepted && !cnt_hit;
    if ((state == ST_CLOSE) && close_ok) loaded_nxt |= 6'b1 << close_type;
    // A segment start drops its loaded bit, even if a close of that type lands now.
    if (cnt_start) loaded_nxt &= ~(6'b1 << iInit_type);
  end

  lstm_init_seg_cnt #(
    .ADDR_W (ADDR_W)
  ) u_seg_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (cnt_start),
    .hit   (cnt_hit),
    .size  (seg_size),
    .addr  (cnt_addr),
    .room  (cnt_room),
    .full  (cnt_full),
    .over  (cnt_over)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cur_type    <= '0;
      seg_live    <= 1'b0;
      close_type  <= '0;
      close_ok    <= 1'b0;
      close_short <= 1'b0;
      oWr_en      <= 1'b0;
      oWr_sel     <= '0;
      oWr_addr    <= '0;
      oWr_data    <= '0;
      oLoaded     <= '0;
      oErr_short  <= 1'b0;
      oErr_over   <= 1'b0;
      oErr_type   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments: every read here sees pre-edge values, so
      // closing the old segment and starting the new one can share one edge.
      oWr_en  <= 1'b0;
      oLoaded <= loaded_nxt;

      if (iClear) begin
        oErr_short <= 1'b0;
        oErr_over  <= 1'b0;
        oErr_type  <= 1'b0;
      end
      if (iInit_valid && (iInit_type == TYPE_RSVD)) oErr_type <= 1'b1;
      if ((state == ST_CLOSE) && !close_ok && close_short) oErr_short <= 1'b1;

      if (cnt_start) begin
        cur_type <= iInit_type;
        oWr_en   <= 1'b1;
        oWr_sel  <= iInit_type;
        oWr_addr <= '0;
        oWr_data <= iInit_data;
      end else if (cnt_hit) begin
        if (cnt_room) begin
          oWr_en   <= 1'b1;
          oWr_sel  <= cur_type;
          oWr_addr <= cnt_addr;
          oWr_data <= iInit_data;
        end else begin
          oErr_over <= 1'b1;
        end
      end

      seg_live <= seg_open && !cnt_hit && accepted;
      if (seg_open) begin
        if (cnt_hit) begin
          state <= ST_LOAD;
        end else begin
          state       <= ST_CLOSE;
          close_type  <= cur_type;
          close_ok    <= cnt_full && !cnt_over;
          close_short <= cnt_room;
        end
      end else begin
        state <= accepted ? ST_LOAD : ST_IDLE;
      end
    end
  end

  assign oSys_ready = &oLoaded[2:0];
  assign oBr_ready  = &oLoaded[5:3];

endmodule

// File: tb/tb_lstm_init_rx.sv
// tb_lstm_init_rx: self-checking bench for lstm_init_rx.
// A segment-level reference model groups the driven byte stream into runs of
// one type and derives the expected write list and flag state from the lengths.
module tb_lstm_init_rx;

  localparam int ADDR_W = 15;
  localparam int SZ [6] = '{32768, 256, 128, 32768, 256, 128};

  logic              clk = 1'b0;
  logic              rst;
  logic              iInit_valid;
  logic [2:0]        iInit_type;
  logic [7:0]        iInit_data;
  logic              iClear;
  logic              oWr_en;
  logic [2:0]        oWr_sel;
  logic [ADDR_W-1:0] oWr_addr;
  logic [7:0]        oWr_data;
  logic [5:0]        oLoaded;
  logic              oSys_ready, oBr_ready;
  logic              oErr_short, oErr_over, oErr_type;

  int total = 0;
  int bad   = 0;

  logic [25:0] got_q [$];
  logic [25:0] exp_q [$];

  // reference model state
  logic [5:0] m_loaded;
  logic       m_short, m_over, m_type, m_open;
  int         m_t, m_n;

  lstm_init_rx dut (
    .clk         (clk),
    .rst         (rst),
    .iInit_valid (iInit_valid),
    .iInit_type  (iInit_type),
    .iInit_data  (iInit_data),
    .iClear      (iClear),
    .oWr_en      (oWr_en),
    .oWr_sel     (oWr_sel),
    .oWr_addr    (oWr_addr),
    .oWr_data    (oWr_data),
    .oLoaded     (oLoaded),
    .oSys_ready  (oSys_ready),
    .oBr_ready   (oBr_ready),
    .oErr_short  (oErr_short),
    .oErr_over   (oErr_over),
    .oErr_type   (oErr_type)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (oWr_en === 1'b1) got_q.push_back({oWr_sel, oWr_addr, oWr_data});

  function automatic void model_cycle(logic v, logic [2:0] t, logic [7:0] d, logic c, logic r);
    if (r) begin
      m_open = 0; m_n = 0; m_loaded = '0; m_short = 0; m_over = 0; m_type = 0;
      return;
    end
    if (c) begin
      m_loaded = '0; m_short = 0; m_over = 0; m_type = 0;
    end
    if (v && t == 3'd6) m_type = 1;
    if (m_open && v && t <= 3'd5 && int'(t) == m_t) begin
      m_n++;
      if (m_n <= SZ[m_t]) exp_q.push_back({t, ADDR_W'(m_n - 1), d});
      else m_over = 1;
    end else begin
      if (m_open) begin
        if (m_n == SZ[m_t]) m_loaded[m_t] = 1'b1;
        else if (m_n < SZ[m_t]) m_short = 1;
        m_open = 0;
      end
      if (v && t <= 3'd5) begin
        m_open = 1; m_t = int'(t); m_n = 1;
        m_loaded[t] = 1'b0;
        exp_q.push_back({t, ADDR_W'(0), d});
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [2:0] t, input logic [7:0] d,
                       input logic c, input logic r);
    iInit_valid = v; iInit_type = t; iInit_data = d; iClear = c; rst = r;
    model_cycle(v, t, d, c, r);
    @(negedge clk);
  endtask

  task automatic step(input logic v, input logic [2:0] t, input logic [7:0] d);
    drive(v, t, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 3'd7, 8'h00);
  endtask

  function automatic logic [10:0] obs_flags();
    return {oLoaded, oSys_ready, oBr_ready, oErr_short, oErr_over, oErr_type};
  endfunction

  function automatic logic [10:0] exp_flags();
    return {m_loaded, &m_loaded[2:0], &m_loaded[5:3], m_short, m_over, m_type};
  endfunction

  function automatic logic [37:0] all_out();
    return {oWr_en, oWr_sel, oWr_addr, oWr_data, oLoaded, oSys_ready, oBr_ready,
            oErr_short, oErr_over, oErr_type};
  endfunction

  // Index of the first differing write over the common prefix, -1 if none.
  function automatic int first_diff();
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic fresh_queues();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    drive(1'b0, 3'd7, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 3'd7, 8'h00, 1'b0, 1'b1);
    total++;
    if (all_out() !== 38'd0) begin
      bad++; $display("FAIL reset_state: got %h want 0", all_out());
    end
    fresh_queues();
  endtask

  task automatic test_reset_mid();
    int d;
    fresh_queues();
    for (int k = 0; k < 1000; k++) step(1'b1, 3'd3, 8'(k));
    drive(1'b0, 3'd7, 8'h00, 1'b0, 1'b1);
    total++;
    if (all_out() !== 38'd0) begin
      bad++; $display("FAIL reset_mid_outputs: got %h want 0", all_out());
    end
    idle(3);
    total++;
    if (got_q.size() !== 1000) begin
      bad++; $display("FAIL reset_mid_wcount: got %0d want 1000", got_q.size());
    end
    d = first_diff();
    total++;
    if (d >= 0) begin
      bad++; $display("FAIL reset_mid_wdata[%0d]: got %h want %h", d, got_q[d], exp_q[d]);
    end
    total++;
    if (obs_flags() !== exp_flags()) begin
      bad++; $display("FAIL reset_mid_flags: got %b want %b", obs_flags(), exp_flags());
    end
  endtask

  task automatic test_full_segment();
    int d;
    fresh_queues();
    for (int k = 0; k < 32768; k++) step(1'b1, 3'd3, 8'(k));
    step(1'b0, 3'd7, 8'h00);
    total++;
    if (oLoaded[3] !== 1'b0) begin
      bad++; $display("FAIL full_loaded_early: got %b want 0", oLoaded[3]);
    end
    step(1'b0, 3'd7, 8'h00);
    total++;
    if (oLoaded[3] !== 1'b1) begin
      bad++; $display("FAIL full_loaded_at_2: got %b want 1", oLoaded[3]);
    end
    idle(2);
    total++;
    if (got_q.size() !== exp_q.size() || got_q.size() !== 32768) begin
      bad++; $display("FAIL full_wcount: got %0d want %0d", got_q.size(), 32768);
    end
    d = first_diff();
    total++;
    if (d >= 0) begin
      bad++; $display("FAIL full_wdata[%0d]: got %h want %h", d, got_q[d], exp_q[d]);
    end
    total++;
    if ({oErr_short, oErr_over, oErr_type} !== 3'b000) begin
      bad++; $display("FAIL full_errors: got %b want 000", {oErr_short, oErr_over, oErr_type});
    end
    total++;
    if (obs_flags() !== exp_flags()) begin
      bad++; $display("FAIL full_flags: got %b want %b", obs_flags(), exp_flags());
    end
  endtask

  task automatic test_short_over();
    int d;
    fresh_queues();
    for (int k = 0; k < 100; k++) step(1'b1, 3'd4, 8'($urandom));
    idle(3);
    total++;
    if (got_q.size() !== 100) begin
      bad++; $display("FAIL short_wcount: got %0d want 100", got_q.size());
    end
    total++;
    if ({oErr_short, oLoaded[4]} !== 2'b10) begin
      bad++; $display("FAIL short_flags: got short=%b loaded4=%b want 1/0", oErr_short, oLoaded[4]);
    end
    fresh_queues();
    for (int k = 0; k < 130; k++) step(1'b1, 3'd5, 8'($urandom));
    idle(3);
    total++;
    if (got_q.size() !== 128) begin
      bad++; $display("FAIL over_wcount: got %0d want 128", got_q.size());
    end
    d = first_diff();
    total++;
    if (d >= 0) begin
      bad++; $display("FAIL over_wdata[%0d]: got %h want %h", d, got_q[d], exp_q[d]);
    end
    total++;
    if ({oErr_over, oLoaded[5]} !== 2'b10) begin
      bad++; $display("FAIL over_flags: got over=%b loaded5=%b want 1/0", oErr_over, oLoaded[5]);
    end
    total++;
    if (obs_flags() !== exp_flags()) begin
      bad++; $display("FAIL short_over_flags: got %b want %b", obs_flags(), exp_flags());
    end
  endtask

  task automatic test_back_to_back();
    int d;
    logic [7:0] b;
    fresh_queues();
    for (int k = 0; k < 256; k++) step(1'b1, 3'd1, 8'($urandom));
    b = 8'($urandom);
    step(1'b1, 3'd2, b);
    total++;
    if ({oWr_en, oWr_sel, oWr_addr, oWr_data} !== {1'b1, 3'd2, 15'd0, b}) begin
      bad++; $display("FAIL b2b_first_write: got en=%b sel=%0d addr=%0d data=%h want 1/2/0/%h",
                      oWr_en, oWr_sel, oWr_addr, oWr_data, b);
    end
    for (int k = 1; k < 128; k++) step(1'b1, 3'd2, 8'($urandom));
    idle(3);
    total++;
    if (got_q.size() !== 384) begin
      bad++; $display("FAIL b2b_wcount: got %0d want 384", got_q.size());
    end
    d = first_diff();
    total++;
    if (d >= 0) begin
      bad++; $display("FAIL b2b_wdata[%0d]: got %h want %h", d, got_q[d], exp_q[d]);
    end
    total++;
    if (oLoaded[2:1] !== 2'b11) begin
      bad++; $display("FAIL b2b_loaded: got %b want 11", oLoaded[2:1]);
    end
  endtask

  task automatic test_all_six();
    int d;
    fresh_queues();
    for (int k = 0; k < 32768; k++) step(1'b1, 3'd0, 8'($urandom));
    idle(2);
    for (int t = 1; t < 6; t++) begin
      if (t == 3) continue;
      for (int k = 0; k < SZ[t]; k++) step(1'b1, 3'(t), 8'($urandom));
      idle(2);
    end
    idle(2);
    total++;
    if ({oSys_ready, oBr_ready} !== 2'b11) begin
      bad++; $display("FAIL six_ready: got sys=%b br=%b want 1/1", oSys_ready, oBr_ready);
    end
    d = first_diff();
    total++;
    if (d >= 0 || got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL six_writes: got %0d writes (first diff %0d) want %0d",
                      got_q.size(), d, exp_q.size());
    end
    total++;
    if (obs_flags() !== exp_flags()) begin
      bad++; $display("FAIL six_flags: got %b want %b", obs_flags(), exp_flags());
    end
    drive(1'b0, 3'd7, 8'h00, 1'b1, 1'b0);
    total++;
    if (obs_flags() !== 11'd0) begin
      bad++; $display("FAIL clear_flags: got %b want 0", obs_flags());
    end
  endtask

  task automatic test_types_6_7();
    fresh_queues();
    for (int k = 0; k < 5; k++) step(1'b1, 3'd7, 8'($urandom));
    idle(2);
    total++;
    if (got_q.size() !== 0 || obs_flags() !== 11'd0) begin
      bad++; $display("FAIL type7: got writes=%0d flags=%b want 0/0", got_q.size(), obs_flags());
    end
    for (int k = 0; k < 3; k++) step(1'b1, 3'd6, 8'($urandom));
    idle(2);
    total++;
    if (got_q.size() !== 0 || oErr_type !== 1'b1) begin
      bad++; $display("FAIL type6: got writes=%0d err_type=%b want 0/1", got_q.size(), oErr_type);
    end
    total++;
    if (obs_flags() !== exp_flags()) begin
      bad++; $display("FAIL type6_flags: got %b want %b", obs_flags(), exp_flags());
    end
  endtask

  task automatic test_random();
    int d, t, len, sz;
    int picks [6] = '{1, 2, 4, 5, 6, 7};
    fresh_queues();
    for (int s = 0; s < 16; s++) begin
      t = picks[$urandom_range(0, 5)];
      if (t >= 6) begin
        len = $urandom_range(1, 3);
      end else begin
        sz = SZ[t];
        case ($urandom_range(0, 3))
          0:       len = sz;
          1:       len = sz - 1;
          2:       len = sz + 2;
          default: len = $urandom_range(1, sz);
        endcase
      end
      for (int k = 0; k < len; k++) step(1'b1, 3'(t), 8'($urandom));
      idle($urandom_range(0, 2));
    end
    idle(4);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL rand_wcount: got %0d want %0d", got_q.size(), exp_q.size());
    end
    d = first_diff();
    total++;
    if (d >= 0) begin
      bad++; $display("FAIL rand_wdata[%0d]: got %h want %h", d, got_q[d], exp_q[d]);
    end
    total++;
    if (obs_flags() !== exp_flags()) begin
      bad++; $display("FAIL rand_flags: got %b want %b", obs_flags(), exp_flags());
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_full_segment();
    test_short_over();
    test_back_to_back();
    test_all_six();
    test_types_6_7();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
